// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } bcd_state_t;

  localparam int         BCD_NIBBLE_W    = 4;
  localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;

  // Used at elaboration to check that the digit count can hold the input range.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_digit_adjust.sv
// Double-dabble nibble correction: add 3 to a BCD nibble holding 5..9.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_NIBBLE_W-1:0] i_nib,
  output logic [BCD_NIBBLE_W-1:0] o_nib
);

  // Inputs are at most 9 here, so the 4-bit sum never wraps.
  assign o_nib = (i_nib >= BCD_ADD3_THRESH) ? i_nib + 4'd3 : i_nib;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one double-dabble step per clock.
// Optional leading-zero blank mask enabled by BCD_LEADING_ZERO_BLANK_EN.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int IN_WIDTH   = 8,
  parameter int BCD_DIGITS = 3
) (
  input  logic                               CLOCK_50_I,
  input  logic                               reset,
  input  logic                               start,
  input  logic [IN_WIDTH-1:0]                bin_in,
  output logic                               busy,
  output logic                               done,
  output logic [BCD_NIBBLE_W*BCD_DIGITS-1:0] bcd_out,
  output logic [BCD_DIGITS-1:0]              bcd_blank
);

  localparam int SW = BCD_NIBBLE_W * BCD_DIGITS;
  localparam int RW = SW + IN_WIDTH;
  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam logic [CW-1:0] LAST    = CW'(IN_WIDTH - 1);
  localparam logic [63:0]   MAX_IN  = (64'd1 << IN_WIDTH) - 64'd1;

  generate
    if (pow10(BCD_DIGITS) <= MAX_IN) begin : g_cap_chk
      $error("bin_to_bcd_seq: BCD_DIGITS too small for IN_WIDTH");
    end
  endgenerate

  bcd_state_t      r_state;
  logic [RW-1:0]   r_sh;
  logic [CW-1:0]   r_cnt;
  logic [SW-1:0]   w_adj;
  logic [RW-1:0]   w_next;
  logic [SW-1:0]   w_scr;
  logic [BCD_DIGITS-1:0] w_blank;

  // Adjust the scratch digits of the current register, then shift, in one cycle.
  generate
    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
        .i_nib(r_sh[IN_WIDTH + g*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
        .o_nib(w_adj[g*BCD_NIBBLE_W +: BCD_NIBBLE_W])
      );
    end
  endgenerate

  assign w_next = {w_adj, r_sh[IN_WIDTH-1:0]} << 1;
  assign w_scr  = w_next[RW-1:IN_WIDTH];

`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic w_hz;
  always_comb begin
    w_blank = '0;
    w_hz    = 1'b1;
    for (int i = BCD_DIGITS - 1; i >= 1; i--) begin
      w_hz       = w_hz & (w_scr[i*BCD_NIBBLE_W +: BCD_NIBBLE_W] == 4'd0);
      w_blank[i] = w_hz;
    end
  end
`else
  assign w_blank = '0;
`endif

  always_ff @(posedge CLOCK_50_I) begin
    if (reset) begin
      r_state   <= IDLE;
      r_sh      <= '0;
      r_cnt     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd_out   <= '0;
      bcd_blank <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sh    <= {{SW{1'b0}}, bin_in};
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_sh  <= w_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            bcd_out   <= w_scr;
            bcd_blank <= w_blank;
            done      <= 1'b1;
            busy      <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed-vector bench for bin_to_bcd_seq (default 8-bit in, 3 digits).
module tb_bin_to_bcd_seq;

`ifdef BCD_LEADING_ZERO_BLANK_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start;
  logic [7:0]  bin_in;
  logic        busy, done;
  logic [11:0] bcd_out;
  logic [2:0]  bcd_blank;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.IN_WIDTH(8), .BCD_DIGITS(3)) dut (
    .CLOCK_50_I(clk),
    .reset     (reset),
    .start     (start),
    .bin_in    (bin_in),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out),
    .bcd_blank (bcd_blank)
  );

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic [2:0]  blank;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Pulse start for one edge; returns #1 after the accepting edge.
  task automatic kick_now(input logic [7:0] v);
    start  = 1'b1;
    bin_in = v;
    @(posedge clk); #1;
    start  = 1'b0;
    bin_in = 8'hA5;
  endtask

  task automatic kick(input logic [7:0] v);
    @(negedge clk);
    kick_now(v);
  endtask

  // Counts edges until done is seen (bounded); also counts busy samples.
  task automatic wait_done(output int lat, output int busyc);
    lat = 0; busyc = 0;
    while (!done && lat < 20) begin
      if (busy) busyc++;
      @(posedge clk); #1;
      lat++;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_done: timeout after %0d cycles", lat);
    end
  endtask

  task automatic watch_quiet(input int cycles, output int dones, output int busys);
    dones = 0; busys = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (busy) busys++;
    end
  endtask

  function automatic logic [11:0] model_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [2:0] model_blank(input int v);
    if (!BLK) return 3'b000;
    return {v < 100, v < 10, 1'b0};
  endfunction

  initial begin
    int lat, bc, nd, nb, badlat;

    tbl[0] = '{8'd0,   12'h000, 3'b110};
    tbl[1] = '{8'd255, 12'h255, 3'b000};
    tbl[2] = '{8'd7,   12'h007, 3'b110};
    tbl[3] = '{8'd10,  12'h010, 3'b100};
    tbl[4] = '{8'd99,  12'h099, 3'b100};
    tbl[5] = '{8'd100, 12'h100, 3'b000};
    tbl[6] = '{8'd128, 12'h128, 3'b000};
    tbl[7] = '{8'd9,   12'h009, 3'b110};

    reset = 1'b1; start = 1'b0; bin_in = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_bcd",   32'(bcd_out),   32'd0);
    chk("rst_blank", 32'(bcd_blank), 32'd0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      kick(tbl[i].bin);
      wait_done(lat, bc);
      chk($sformatf("tbl%0d_bcd", i),   32'(bcd_out),   32'(tbl[i].bcd));
      chk($sformatf("tbl%0d_blank", i), 32'(bcd_blank), BLK ? 32'(tbl[i].blank) : 32'd0);
      chk($sformatf("tbl%0d_lat", i),   32'(lat), 32'd8);
      chk($sformatf("tbl%0d_busy", i),  32'(bc),  32'd8);
      chk($sformatf("tbl%0d_dbusy", i), 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_pulse", i), 32'(done), 32'd0);
    end

    // start during SHIFT must be dropped, not queued
    kick(8'd99);
    @(posedge clk); #1;
    @(posedge clk); #1;
    kick_now(8'd7);
    wait_done(lat, bc);
    chk("ign_lat", 32'(lat), 32'd5);
    chk("ign_bcd", 32'(bcd_out), 32'h099);
    watch_quiet(15, nd, nb);
    chk("ign_no_done", 32'(nd), 32'd0);
    chk("ign_no_busy", 32'(nb), 32'd0);
    chk("ign_hold",    32'(bcd_out), 32'h099);

    // start held in the done cycle is accepted
    kick(8'd42);
    wait_done(lat, bc);
    chk("b2b_bcd0", 32'(bcd_out), 32'h042);
    kick_now(8'd100);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_hold", 32'(bcd_out), 32'h042);
    wait_done(lat, bc);
    chk("b2b_lat",  32'(lat), 32'd8);
    chk("b2b_bcd1", 32'(bcd_out), 32'h100);

    // reset mid-conversion discards it
    kick(8'd200);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mrst_busy",  32'(busy),      32'd0);
    chk("mrst_done",  32'(done),      32'd0);
    chk("mrst_bcd",   32'(bcd_out),   32'd0);
    chk("mrst_blank", 32'(bcd_blank), 32'd0);
    reset = 1'b0;
    watch_quiet(20, nd, nb);
    chk("mrst_no_done", 32'(nd), 32'd0);

    // back-to-back sweep of the full input range
    badlat = 0;
    @(negedge clk);
    for (int v = 0; v < 256; v++) begin
      kick_now(8'(v));
      wait_done(lat, bc);
      if (lat != 8) badlat++;
      chk($sformatf("sweep%0d_bcd", v),   32'(bcd_out),   32'(model_bcd(v)));
      chk($sformatf("sweep%0d_blank", v), 32'(bcd_blank), 32'(model_blank(v)));
    end
    chk("sweep_lat_errs", 32'(badlat), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
